mc_ctrl_fsm: RTL and testbench

Parametrised multicycle MIPS control unit. It is the successor to the fixed control_unit and sits between the instruction register opcode field and the datapath muxes and write strobes. It adds addi and j support, configurable memory latency, write strobes qualified by clk_en, an instruction-done pulse, and sticky illegal-opcode halt. It advances only on cycles where clk_en (from clk_divider) is high.

---
 rtl/mc_ctrl_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences the datapath muxes and write strobes
// per instruction, with stretched memory states and a sticky illegal-opcode halt.
module mc_ctrl_fsm #(
  parameter int MEM_LAT = 1,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [5:0] opcode,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       MemRead,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state_dbg,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       isSw_q, isSw_d;
  logic       illegal_q, illegal_d;

  state_t     decodeTarget;
  logic       memState;
  logic       lastWait;
  logic       fire;

  always_comb begin
    decodeTarget = HALT;
    case (opcode)
      OP_RTYPE:     decodeTarget = EXEC;
      OP_LW, OP_SW: decodeTarget = MEMADR;
      OP_BEQ:       decodeTarget = BRANCH;
      OP_ADDI:      decodeTarget = EN_ADDI ? ADDIEX : HALT;
      OP_J:         decodeTarget = EN_JUMP ? JUMP : HALT;
      default:      decodeTarget = HALT;
    endcase
  end

  // Non-memory states always sit on their last (only) wait cycle.
  assign memState = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign lastWait = !memState || (wait_q == LAST_WAIT);
  assign fire     = clk_en && lastWait && rst;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    isSw_d    = isSw_q;
    illegal_d = illegal_q;
    if (clk_en) begin
      if (!lastWait) begin
        wait_d = wait_q + 4'd1;
      end else begin
        wait_d = 4'd0;
        case (state_q)
          FETCH:  state_d = DECODE;
          DECODE: begin
            state_d = decodeTarget;
            isSw_d  = (opcode == OP_SW);
            if (decodeTarget == HALT) illegal_d = 1'b1;
          end
          MEMADR: state_d = isSw_q ? MEMWR : MEMRD;
          MEMRD:  state_d = MEMWB;
          EXEC:   state_d = ALUWB;
          ADDIEX: state_d = ADDIWB;
          MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
          HALT:   state_d = HALT;
          default: state_d = HALT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      wait_q    <= 4'd0;
      isSw_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      isSw_q    <= isSw_d;
      illegal_q <= illegal_d;
    end
  end

  // Level controls follow the state; strobes and done also need an enabled last cycle.
  always_comb begin
    IorD        = 1'b0;
    ALUSrcA     = 1'b0;
    MemRead     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    instr_done  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = fire;
        PCWrite = fire;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = fire;
        instr_done = fire;
      end
      MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = fire;
        instr_done = fire;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = fire;
        instr_done = fire;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSrc       = 2'b01;
        PCWriteCond = fire;
        instr_done  = fire;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite   = fire;
        instr_done = fire;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = fire;
        instr_done = fire;
      end
      default: ;
    endcase
  end

  assign state_dbg  = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a MEM_LAT=1 instance and a MEM_LAT=3 / no-jump instance share stimulus.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [5:0] opcode;

  logic       aIorD, aAluSrcA, aMemRead, aRegDst, aMemtoReg;
  logic       aIrWrite, aPcWrite, aPcWriteCond, aMemWrite, aRegWrite;
  logic [1:0] aAluSrcB, aAluOp, aPcSrc;
  logic [3:0] aState;
  logic       aDone, aIllegal;

  logic       bIorD, bAluSrcA, bMemRead, bRegDst, bMemtoReg;
  logic       bIrWrite, bPcWrite, bPcWriteCond, bMemWrite, bRegWrite;
  logic [1:0] bAluSrcB, bAluOp, bPcSrc;
  logic [3:0] bState;
  logic       bDone, bIllegal;

  int checks = 0;
  int failures = 0;

  int aRwCnt, aDoneCnt, aStrobeCnt;
  int bIrCnt, bMwCnt, bRwCnt, bDoneCnt;

  int exp1[5]  = '{0, 1, 6, 7, 0};
  int exp2[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
  int exp3[9]  = '{0, 0, 0, 1, 2, 5, 5, 5, 0};
  int exp4[4]  = '{0, 1, 8, 0};
  int exp6[6]  = '{0, 0, 0, 1, 2, 5};

  mc_ctrl_fsm #(.MEM_LAT(1), .EN_ADDI(1'b1), .EN_JUMP(1'b1)) dutA (
    .clk_100M(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode),
    .IorD(aIorD), .ALUSrcA(aAluSrcA), .MemRead(aMemRead), .RegDst(aRegDst),
    .MemtoReg(aMemtoReg), .IRWrite(aIrWrite), .PCWrite(aPcWrite),
    .PCWriteCond(aPcWriteCond), .MemWrite(aMemWrite), .RegWrite(aRegWrite),
    .ALUSrcB(aAluSrcB), .ALUOp(aAluOp), .PCSrc(aPcSrc), .state_dbg(aState),
    .instr_done(aDone), .illegal_op(aIllegal)
  );

  mc_ctrl_fsm #(.MEM_LAT(3), .EN_ADDI(1'b1), .EN_JUMP(1'b0)) dutB (
    .clk_100M(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode),
    .IorD(bIorD), .ALUSrcA(bAluSrcA), .MemRead(bMemRead), .RegDst(bRegDst),
    .MemtoReg(bMemtoReg), .IRWrite(bIrWrite), .PCWrite(bPcWrite),
    .PCWriteCond(bPcWriteCond), .MemWrite(bMemWrite), .RegWrite(bRegWrite),
    .ALUSrcB(bAluSrcB), .ALUOp(bAluOp), .PCSrc(bPcSrc), .state_dbg(bState),
    .instr_done(bDone), .illegal_op(bIllegal)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] op);
    clk_en = en;
    opcode = op;
  endtask

  task automatic clearCounts();
    aRwCnt = 0; aDoneCnt = 0; aStrobeCnt = 0;
    bIrCnt = 0; bMwCnt = 0; bRwCnt = 0; bDoneCnt = 0;
  endtask

  // Samples on the falling edge so combinational strobes are counted once per cycle
  task automatic sampleCycle();
    @(negedge clk);
    aRwCnt     += int'(aRegWrite);
    aDoneCnt   += int'(aDone);
    aStrobeCnt += int'(aIrWrite) + int'(aPcWrite) + int'(aPcWriteCond)
                + int'(aMemWrite) + int'(aRegWrite) + int'(aDone);
    bIrCnt   += int'(bIrWrite);
    bMwCnt   += int'(bMemWrite);
    bRwCnt   += int'(bRegWrite);
    bDoneCnt += int'(bDone);
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clk_en = 1'b0;
    #1;
    nextEdge();
    nextEdge();
    rst = 1'b1;
  endtask

  // Directed sequence of scenarios, all with fixed cycle counts
  initial begin
    rst = 1'b0;
    clk_en = 1'b0;
    opcode = 6'b000000;
    clearCounts();

    // Reset state
    doReset();
    checkOutput("reset_state", int'(aState), 0);
    checkOutput("reset_illegal", int'(aIllegal), 0);
    checkOutput("reset_memread", int'(aMemRead), 1);
    checkOutput("reset_alusrcb", int'(aAluSrcB), 1);

    // R-type with clk_en every 5th clock
    applyStimulus(1'b0, 6'b000000);
    clearCounts();
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 5; k++) begin
        clk_en = (k == 4);
        sampleCycle();
        checkOutput("rtype_state", int'(aState), exp1[s]);
        if (s == 3) begin
          checkOutput("rtype_regwrite", int'(aRegWrite), int'(k == 4));
          checkOutput("rtype_regdst", int'(aRegDst), 1);
        end
        nextEdge();
      end
    end
    checkOutput("rtype_rw_count", aRwCnt, 1);
    checkOutput("rtype_done_count", aDoneCnt, 1);

    // lw with MEM_LAT=3
    doReset();
    applyStimulus(1'b1, 6'b100011);
    clearCounts();
    for (int i = 0; i < 10; i++) begin
      sampleCycle();
      checkOutput("lw_state", int'(bState), exp2[i]);
      checkOutput("lw_irwrite", int'(bIrWrite), int'(i == 2));
      if (exp2[i] == 3) begin
        checkOutput("lw_memread", int'(bMemRead), 1);
        checkOutput("lw_iord", int'(bIorD), 1);
      end
      if (i == 8) begin
        checkOutput("lw_regwrite", int'(bRegWrite), 1);
        checkOutput("lw_memtoreg", int'(bMemtoReg), 1);
      end
      nextEdge();
    end
    checkOutput("lw_rw_count", bRwCnt, 1);
    checkOutput("lw_ir_count", bIrCnt, 1);

    // sw with opcode changed during MEMADR
    doReset();
    applyStimulus(1'b1, 6'b101011);
    clearCounts();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) opcode = 6'b000000;
      sampleCycle();
      checkOutput("sw_state", int'(bState), exp3[i]);
      checkOutput("sw_memwrite", int'(bMemWrite), int'(i == 7));
      nextEdge();
    end
    checkOutput("sw_mw_count", bMwCnt, 1);
    checkOutput("sw_rw_count", bRwCnt, 0);
    checkOutput("sw_done_count", bDoneCnt, 1);

    // beq on the MEM_LAT=1 instance
    doReset();
    applyStimulus(1'b1, 6'b000100);
    for (int i = 0; i < 4; i++) begin
      sampleCycle();
      checkOutput("beq_state", int'(aState), exp4[i]);
      if (i == 2) begin
        checkOutput("beq_pcwritecond", int'(aPcWriteCond), 1);
        checkOutput("beq_pcsrc", int'(aPcSrc), 1);
        checkOutput("beq_aluop", int'(aAluOp), 1);
        checkOutput("beq_done", int'(aDone), 1);
      end
      nextEdge();
    end

    // j: decoded on A, illegal on B
    doReset();
    applyStimulus(1'b1, 6'b000010);
    for (int i = 0; i < 5; i++) begin
      sampleCycle();
      if (i == 2) begin
        checkOutput("j_state", int'(aState), 11);
        checkOutput("j_pcwrite", int'(aPcWrite), 1);
        checkOutput("j_pcsrc", int'(aPcSrc), 2);
      end
      if (i == 3) checkOutput("nojump_illegal_early", int'(bIllegal), 0);
      if (i == 4) begin
        checkOutput("nojump_state", int'(bState), 12);
        checkOutput("nojump_illegal", int'(bIllegal), 1);
      end
      nextEdge();
    end

    // Undecodable opcode: sticky halt with everything quiet
    doReset();
    applyStimulus(1'b1, 6'b111111);
    sampleCycle();
    nextEdge();
    sampleCycle();
    checkOutput("halt_illegal_decode", int'(aIllegal), 0);
    nextEdge();
    clearCounts();
    for (int i = 0; i < 100; i++) begin
      sampleCycle();
      nextEdge();
    end
    checkOutput("halt_state", int'(aState), 12);
    checkOutput("halt_illegal", int'(aIllegal), 1);
    checkOutput("halt_strobes", aStrobeCnt, 0);
    checkOutput("halt_memread", int'(aMemRead), 0);
    checkOutput("halt_alusrcb", int'(aAluSrcB), 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_state", int'(aState), 0);
    checkOutput("async_rst_illegal", int'(aIllegal), 0);
    checkOutput("async_rst_memread", int'(aMemRead), 1);
    checkOutput("async_rst_irwrite", int'(aIrWrite), 0);
    nextEdge();
    rst = 1'b1;

    // Reset during the 2nd MEMWR wait cycle
    doReset();
    applyStimulus(1'b1, 6'b101011);
    clearCounts();
    for (int i = 0; i < 6; i++) begin
      sampleCycle();
      checkOutput("rstmid_state", int'(bState), exp6[i]);
      nextEdge();
    end
    rst = 1'b0;
    #1;
    checkOutput("rstmid_state_now", int'(bState), 0);
    checkOutput("rstmid_memwrite_now", int'(bMemWrite), 0);
    sampleCycle();
    nextEdge();
    sampleCycle();
    nextEdge();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sampleCycle();
      checkOutput("restart_state", int'(bState), exp6[i]);
      checkOutput("restart_irwrite", int'(bIrWrite), int'(i == 2));
      nextEdge();
    end
    checkOutput("rstmid_mw_count", bMwCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
